// File: rtl/arm_shifter_seq.sv
// Iterative ARM operand-2 shifter: one bit position per clock, valid/ready on both sides.
// Large amounts fall out of the iteration, giving ARM register-shift semantics for free.
module arm_shifter_seq #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] shift_in,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [2:0]       shift_type,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifter_out,
    output logic             shifter_carry_out
);

    localparam logic [2:0] T_LSL = 3'b000;
    localparam logic [2:0] T_LSR = 3'b001;
    localparam logic [2:0] T_ASR = 3'b010;
    localparam logic [2:0] T_ROR = 3'b011;
    localparam logic [2:0] T_RRX = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_work, w_step_work;
    logic             r_carry, w_step_carry;
    logic [2:0]       r_type;
    logic [AMT_W-1:0] r_count, w_load_cnt;
    logic             w_accept;

    assign w_accept = in_valid && in_ready;

    // RRX always takes exactly one step; illegal types degrade to a pass-through
    always_comb begin
        w_load_cnt = '0;
        case (shift_type)
            T_LSL, T_LSR, T_ASR, T_ROR: w_load_cnt = shift_amt;
            T_RRX:                      w_load_cnt = AMT_W'(1);
            default:                    w_load_cnt = '0;
        endcase
    end

    always_comb begin
        w_step_work  = r_work;
        w_step_carry = r_carry;
        case (r_type)
            T_LSL: begin
                w_step_carry = r_work[WIDTH-1];
                w_step_work  = {r_work[WIDTH-2:0], 1'b0};
            end
            T_LSR: begin
                w_step_carry = r_work[0];
                w_step_work  = {1'b0, r_work[WIDTH-1:1]};
            end
            T_ASR: begin
                w_step_carry = r_work[0];
                w_step_work  = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            end
            T_ROR: begin
                w_step_carry = r_work[0];
                w_step_work  = {r_work[0], r_work[WIDTH-1:1]};
            end
            T_RRX: begin
                w_step_carry = r_work[0];
                w_step_work  = {r_carry, r_work[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = (w_load_cnt == '0) ? S_DONE : S_SHIFT;
            S_SHIFT: if (r_count == AMT_W'(1)) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_carry <= 1'b0;
            r_type  <= 3'b000;
            r_count <= '0;
        end else if (w_accept) begin
            r_work  <= shift_in;
            r_carry <= carry_in;
            r_type  <= shift_type;
            r_count <= w_load_cnt;
        end else if (r_state == S_SHIFT) begin
            r_work  <= w_step_work;
            r_carry <= w_step_carry;
            r_count <= r_count - AMT_W'(1);
        end
    end

    assign shifter_out       = r_work;
    assign shifter_carry_out = r_carry;

endmodule

// File: tb/tb_arm_shifter_seq.sv
// Directed-vector bench for arm_shifter_seq: result, carry, latency, backpressure, async reset.
module tb_arm_shifter_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] shift_in = '0;
    logic [2:0] shift_amt = '0;
    logic [2:0] shift_type = '0;
    logic       carry_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] shifter_out;
    logic       shifter_carry_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arm_shifter_seq #(.WIDTH(4), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .shift_in(shift_in), .shift_amt(shift_amt), .shift_type(shift_type),
        .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .shifter_out(shifter_out), .shifter_carry_out(shifter_carry_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for out_valid, check result/carry/latency; leaves DUT in DONE.
    task automatic issue(input string tag, input logic [2:0] ty, input logic [3:0] d,
                         input logic [2:0] amt, input logic ci,
                         input logic [3:0] exp_d, input logic exp_c, input int exp_lat);
        int lat;
        @(negedge clk);
        shift_type = ty; shift_in = d; shift_amt = amt; carry_in = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        shift_in = ~d; shift_amt = ~amt; carry_in = ~ci;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " lat"},   lat, exp_lat);
        chk({tag, " out"},   shifter_out, exp_d);
        chk({tag, " carry"}, shifter_carry_out, exp_c);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " idle out_valid"}, out_valid, 1'b0);
        chk({tag, " idle in_ready"},  in_ready, 1'b1);
    endtask

    initial begin
        #12;
        chk("reset in_ready",  in_ready, 1'b1);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out",       shifter_out, 4'b0000);
        chk("reset carry",     shifter_carry_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("lsl1011x1",  3'b000, 4'b1011, 3'd1, 1'b0, 4'b0110, 1'b1, 1); release_out("v1");
        issue("asr1000x6",  3'b010, 4'b1000, 3'd6, 1'b0, 4'b1111, 1'b1, 6); release_out("v2");
        issue("ror1001x4",  3'b011, 4'b1001, 3'd4, 1'b0, 4'b1001, 1'b1, 4); release_out("v3");
        issue("lsr0101x0",  3'b001, 4'b0101, 3'd0, 1'b1, 4'b0101, 1'b1, 0); release_out("v4");
        issue("lsl1111x7",  3'b000, 4'b1111, 3'd7, 1'b1, 4'b0000, 1'b0, 7); release_out("v5");
        issue("rrx0011",    3'b100, 4'b0011, 3'd5, 1'b1, 4'b1001, 1'b1, 1); release_out("v6");
        issue("lsr1000x4",  3'b001, 4'b1000, 3'd4, 1'b0, 4'b0000, 1'b1, 4); release_out("v7");
        issue("illegal101", 3'b101, 4'b0110, 3'd3, 1'b0, 4'b0110, 1'b0, 0); release_out("v8");
        issue("asr0110x1",  3'b010, 4'b0110, 3'd1, 1'b1, 4'b0011, 1'b0, 1); release_out("v9");
        issue("ror0001x2",  3'b011, 4'b0001, 3'd2, 1'b1, 4'b0100, 1'b0, 2); release_out("v10");

        // backpressure: result held, new requests ignored while DONE
        issue("bp lsl0011x2", 3'b000, 4'b0011, 3'd2, 1'b0, 4'b1100, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; shift_type = 3'b000; shift_in = 4'b1111; shift_amt = 3'd1; carry_in = 1'b1;
            @(posedge clk);
            #1;
            chk("bp out_valid", out_valid, 1'b1);
            chk("bp in_ready",  in_ready, 1'b0);
            chk("bp out",       shifter_out, 4'b1100);
            chk("bp carry",     shifter_carry_out, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("bp");

        // async reset in the middle of a long shift
        @(negedge clk);
        shift_type = 3'b000; shift_in = 4'b1111; shift_amt = 3'd7; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rst mid in_ready", in_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst mid in_ready",  in_ready, 1'b1);
        chk("rst mid out_valid", out_valid, 1'b0);
        chk("rst mid out",       shifter_out, 4'b0000);
        chk("rst mid carry",     shifter_carry_out, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue("post rst lsr1010x1", 3'b001, 4'b1010, 3'd1, 1'b1, 4'b0101, 1'b0, 1);
        release_out("post rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
